// File: rtl/ram_pkg.sv
// Shared types and default geometry for the RAM sequencing master and its read checker.
package ram_pkg;

    localparam int RAM_WIDTH   = 16;
    localparam int RAM_DEPTH   = 32;
    localparam int RAM_ADDRESS = 5;
    localparam int RAM_ERR_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/ram_seq_master_if.sv
// Dual-port RAM bus: gated write port plus a registered-data read port.
interface ram_seq_master_if
    import ram_pkg::*;
#(
    parameter int WIDTH   = RAM_WIDTH,
    parameter int ADDRESS = RAM_ADDRESS
);

    logic               cs;
    logic               valid;
    logic               wr_en;
    logic [ADDRESS-1:0] wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic               ready;
    logic               rd_en;
    logic [ADDRESS-1:0] rd_addr;
    logic [WIDTH-1:0]   rd_data;

    modport master (
        output cs, valid, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  ready, rd_data
    );

    modport slave (
        input  cs, valid, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output ready, rd_data
    );

endinterface

// File: rtl/ram_rd_checker.sv
// Compare stage: tracks each issued read for one cycle and checks the returned word,
// keeping a saturating mismatch count and the address of the first mismatch.
module ram_rd_checker
    import ram_pkg::*;
#(
    parameter int WIDTH   = RAM_WIDTH,
    parameter int ADDRESS = RAM_ADDRESS,
    parameter int ERR_W   = RAM_ERR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               rd_en,
    input  logic [ADDRESS-1:0] rd_addr,
    input  logic [WIDTH-1:0]   exp_data,
    input  logic [WIDTH-1:0]   rd_data,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [ADDRESS-1:0] first_err
);

    logic               pipe_vld_q,  pipe_vld_d;
    logic [ADDRESS-1:0] pipe_addr_q, pipe_addr_d;
    logic [WIDTH-1:0]   pipe_exp_q,  pipe_exp_d;
    logic [ERR_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [ADDRESS-1:0] first_err_q, first_err_d;

    // A zero count doubles as "no mismatch seen yet" because the counter saturates instead of wrapping.
    always_comb begin
        pipe_vld_d  = rd_en;
        pipe_addr_d = rd_en ? rd_addr  : pipe_addr_q;
        pipe_exp_d  = rd_en ? exp_data : pipe_exp_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        if (clear) begin
            err_cnt_d   = '0;
            first_err_d = '0;
        end else if (pipe_vld_q && (rd_data != pipe_exp_q)) begin
            if (err_cnt_q == '0) first_err_d = pipe_addr_q;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q  <= 1'b0;
            pipe_addr_q <= '0;
            pipe_exp_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_addr_q <= pipe_addr_d;
            pipe_exp_q  <= pipe_exp_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;

endmodule

// File: rtl/ram_seq_master.sv
// RAM init / self-test initiator: writes seed+k over a wrapping region, reads it back,
// and reports pass, mismatch count and first failing address.
module ram_seq_master
    import ram_pkg::*;
#(
    parameter int WIDTH   = RAM_WIDTH,
    parameter int DEPTH   = RAM_DEPTH,
    parameter int ADDRESS = RAM_ADDRESS,
    parameter int ERR_W   = RAM_ERR_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [ADDRESS-1:0] i_base,
    input  logic [ADDRESS:0]   i_len,
    input  logic [WIDTH-1:0]   i_seed,
    input  logic               i_abort,
    ram_seq_master_if.master   ram,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_pass,
    output logic [ERR_W-1:0]   o_err_cnt,
    output logic [ADDRESS-1:0] o_first_err
);

    state_t             state_q,   state_d;
    logic [ADDRESS:0]   k_q,       k_d;
    logic [ADDRESS-1:0] base_q,    base_d;
    logic [ADDRESS:0]   len_q,     len_d;
    logic [WIDTH-1:0]   seed_q,    seed_d;
    logic               aborted_q, aborted_d;
    logic               wr_req_q,  wr_req_d;
    logic [ADDRESS-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;
    logic               rd_en_q,   rd_en_d;
    logic [ADDRESS-1:0] rd_addr_q, rd_addr_d;
    logic [WIDTH-1:0]   rd_exp_q,  rd_exp_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               pass_q,    pass_d;
    logic               chk_clear;
    logic [ADDRESS:0]   k_inc;
    logic               last;
    logic [ERR_W-1:0]   err_cnt;
    logic [ADDRESS-1:0] first_err;

    function automatic logic [ADDRESS-1:0] region_addr(input logic [ADDRESS-1:0] b,
                                                       input logic [ADDRESS:0] k);
        return ADDRESS'((int'(b) + int'(k)) % DEPTH);
    endfunction

    function automatic logic [WIDTH-1:0] pattern(input logic [WIDTH-1:0] s,
                                                 input logic [ADDRESS:0] k);
        return s + WIDTH'(k);
    endfunction

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        base_d    = base_q;
        len_d     = len_q;
        seed_d    = seed_q;
        aborted_d = aborted_q;
        wr_req_d  = wr_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        rd_exp_d  = rd_exp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        chk_clear = 1'b0;
        k_inc     = k_q + 1'b1;
        last      = (k_q == len_q - 1'b1);
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    base_d    = i_base;
                    len_d     = i_len;
                    seed_d    = i_seed;
                    k_d       = '0;
                    aborted_d = 1'b0;
                    busy_d    = 1'b1;
                    pass_d    = 1'b0;
                    chk_clear = 1'b1;
                    if (i_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d   = WRITE;
                        wr_req_d  = 1'b1;
                        wr_addr_d = i_base;
                        wr_data_d = i_seed;
                    end
                end
            end
            // Index only moves on an accepted write; a stalled write keeps its address and data.
            WRITE: begin
                if (i_abort) begin
                    wr_req_d  = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (ram.ready) begin
                    if (last) begin
                        wr_req_d  = 1'b0;
                        k_d       = '0;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_q;
                        rd_exp_d  = seed_q;
                        state_d   = READ;
                    end else begin
                        k_d       = k_inc;
                        wr_addr_d = region_addr(base_q, k_inc);
                        wr_data_d = pattern(seed_q, k_inc);
                    end
                end
            end
            READ: begin
                if (i_abort) begin
                    rd_en_d   = 1'b0;
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else if (last) begin
                    rd_en_d = 1'b0;
                    state_d = DRAIN;
                end else begin
                    k_d       = k_inc;
                    rd_addr_d = region_addr(base_q, k_inc);
                    rd_exp_d  = pattern(seed_q, k_inc);
                end
            end
            DRAIN: begin
                if (i_abort) aborted_d = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_cnt == '0) && !aborted_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            base_q    <= '0;
            len_q     <= '0;
            seed_q    <= '0;
            aborted_q <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_exp_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            base_q    <= base_d;
            len_q     <= len_d;
            seed_q    <= seed_d;
            aborted_q <= aborted_d;
            wr_req_q  <= wr_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_exp_q  <= rd_exp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    ram_rd_checker #(
        .WIDTH   (WIDTH),
        .ADDRESS (ADDRESS),
        .ERR_W   (ERR_W)
    ) u_checker (
        .clk       (i_clk),
        .rst       (i_rst),
        .clear     (chk_clear),
        .rd_en     (rd_en_q),
        .rd_addr   (rd_addr_q),
        .exp_data  (rd_exp_q),
        .rd_data   (ram.rd_data),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

    assign ram.cs      = wr_req_q;
    assign ram.valid   = wr_req_q;
    assign ram.wr_en   = wr_req_q;
    assign ram.wr_addr = wr_addr_q;
    assign ram.wr_data = wr_data_q;
    assign ram.rd_en   = rd_en_q;
    assign ram.rd_addr = rd_addr_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_pass      = pass_q;
    assign o_err_cnt   = err_cnt;
    assign o_first_err = first_err;

endmodule

// File: tb/tb_ram_seq_master.sv
// Scoreboard bench for ram_seq_master: a behavioural RAM, queues of expected writes,
// reads and results, and a negedge monitor that pops and compares as the DUT acts.
module tb_ram_seq_master;

    localparam int WIDTH   = 16;
    localparam int DEPTH   = 32;
    localparam int ADDRESS = 5;
    localparam int ERR_W   = 8;

    typedef struct packed {
        logic [ADDRESS-1:0] addr;
        logic [WIDTH-1:0]   data;
    } wr_item_t;

    typedef struct packed {
        logic               pass;
        logic [ERR_W-1:0]   err;
        logic [ADDRESS-1:0] first;
    } res_item_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic [ADDRESS-1:0] base;
    logic [ADDRESS:0]   len;
    logic [WIDTH-1:0]   seed;
    logic               busy;
    logic               done;
    logic               pass;
    logic [ERR_W-1:0]   err_cnt;
    logic [ADDRESS-1:0] first_err;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]   corrupt_mask;
    bit                 rand_ready;

    wr_item_t           wr_q [$];
    logic [ADDRESS-1:0] rd_q [$];
    res_item_t          res_q [$];

    int                 vectors     = 0;
    int                 miscompares = 0;

    logic               stall_prev;
    logic [ADDRESS-1:0] stall_addr;
    logic [WIDTH-1:0]   stall_data;

    ram_seq_master_if #(.WIDTH(WIDTH), .ADDRESS(ADDRESS)) ram_if ();

    ram_seq_master #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .ADDRESS (ADDRESS),
        .ERR_W   (ERR_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base      (base),
        .i_len       (len),
        .i_seed      (seed),
        .i_abort     (abort),
        .ram         (ram_if),
        .o_busy      (busy),
        .o_done      (done),
        .o_pass      (pass),
        .o_err_cnt   (err_cnt),
        .o_first_err (first_err)
    );

    always #5 clk = ~clk;

    // Behavioural RAM; reads of addresses flagged in corrupt_mask come back with bit 0 flipped.
    always @(posedge clk) begin
        if (ram_if.cs && ram_if.valid && ram_if.wr_en && ram_if.ready)
            mem[ram_if.wr_addr] <= ram_if.wr_data;
        if (ram_if.rd_en)
            ram_if.rd_data <= mem[ram_if.rd_addr] ^ (corrupt_mask[ram_if.rd_addr] ? 16'h0001 : 16'h0000);
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: region addresses wrap modulo DEPTH, data is seed+k, errors come from corrupted reads.
    task automatic push_expected(input logic [ADDRESS-1:0] b, input int n, input logic [WIDTH-1:0] s,
                                 input int n_reads, input bit aborted, output logic exp_pass);
        int        errs  = 0;
        int        first = 0;
        res_item_t r;
        for (int k = 0; k < n; k++) begin
            wr_item_t it;
            it.addr = ADDRESS'((int'(b) + k) % DEPTH);
            it.data = WIDTH'(int'(s) + k);
            wr_q.push_back(it);
        end
        for (int k = 0; k < n_reads; k++) begin
            int a = (int'(b) + k) % DEPTH;
            rd_q.push_back(ADDRESS'(a));
            if (corrupt_mask[a]) begin
                if (errs == 0) first = a;
                errs++;
            end
        end
        r.pass   = (errs == 0) && !aborted;
        r.err    = ERR_W'((errs > 255) ? 255 : errs);
        r.first  = ADDRESS'(first);
        exp_pass = r.pass;
        res_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ram_if.ready = 1'($urandom_range(0, 1));
    endtask

    task automatic flush_queues();
        wr_q.delete();
        rd_q.delete();
        res_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check_output({tag, " busy"},      busy,           0);
        check_output({tag, " done"},      done,           0);
        check_output({tag, " pass"},      pass,           0);
        check_output({tag, " err_cnt"},   err_cnt,        0);
        check_output({tag, " first_err"}, first_err,      0);
        check_output({tag, " cs"},        ram_if.cs,      0);
        check_output({tag, " valid"},     ram_if.valid,   0);
        check_output({tag, " wr_en"},     ram_if.wr_en,   0);
        check_output({tag, " wr_addr"},   ram_if.wr_addr, 0);
        check_output({tag, " wr_data"},   ram_if.wr_data, 0);
        check_output({tag, " rd_en"},     ram_if.rd_en,   0);
        check_output({tag, " rd_addr"},   ram_if.rd_addr, 0);
    endtask

    // Issues one command; optional 3-cycle ready stall on write index stall_k; latency < 0 skips that check.
    task automatic apply_stimulus(input logic [ADDRESS-1:0] b, input int n, input logic [WIDTH-1:0] s,
                                  input int exp_latency, input int stall_k);
        logic exp_pass;
        int   cycles     = 1;
        int   stall_left = 0;
        bit   stalled    = 1'b0;
        push_expected(b, n, s, n, 1'b0, exp_pass);
        tick();
        base  = b;
        len   = (ADDRESS+1)'(n);
        seed  = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && cycles < 3000) begin
            if (stall_k >= 0 && !stalled && ram_if.cs &&
                ram_if.wr_addr == ADDRESS'((int'(b) + stall_k) % DEPTH)) begin
                ram_if.ready = 1'b0;
                stall_left   = 3;
                stalled      = 1'b1;
            end
            tick();
            cycles++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) ram_if.ready = 1'b1;
            end
        end
        check_output("done seen", done, 1);
        if (exp_latency >= 0) check_output("latency", cycles, exp_latency);
        tick();
        tick();
        check_output("pass held", pass, exp_pass);
        check_output("busy after done", busy, 0);
        check_output("writes outstanding", 32'(wr_q.size()), 0);
        check_output("reads outstanding", 32'(rd_q.size()), 0);
        if (!done && cycles >= 3000) flush_queues();
    endtask

    // Monitor: pops expected writes/reads/results as the DUT presents them, and checks stalled writes hold.
    always @(negedge clk) begin
        if (ram_if.cs && ram_if.valid && ram_if.wr_en && ram_if.ready) begin
            check_output("write expected", 32'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                wr_item_t it;
                it = wr_q.pop_front();
                check_output("wr_addr", ram_if.wr_addr, it.addr);
                check_output("wr_data", ram_if.wr_data, it.data);
            end
        end
        if (stall_prev) begin
            check_output("stall cs held", ram_if.cs, 1);
            check_output("stall wr_addr held", ram_if.wr_addr, stall_addr);
            check_output("stall wr_data held", ram_if.wr_data, stall_data);
        end
        stall_prev <= ram_if.cs && !ram_if.ready && !rst;
        stall_addr <= ram_if.wr_addr;
        stall_data <= ram_if.wr_data;
        if (ram_if.rd_en) begin
            check_output("read expected", 32'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) begin
                logic [ADDRESS-1:0] a;
                a = rd_q.pop_front();
                check_output("rd_addr", ram_if.rd_addr, a);
            end
        end
        if (done) begin
            check_output("result expected", 32'(res_q.size() > 0), 1);
            if (res_q.size() > 0) begin
                res_item_t r;
                r = res_q.pop_front();
                check_output("pass", pass, r.pass);
                check_output("err_cnt", err_cnt, r.err);
                check_output("first_err", first_err, r.first);
                check_output("busy at done", busy, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic p;
        int   cycles;
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        base         = '0;
        len          = '0;
        seed         = '0;
        rand_ready   = 1'b0;
        corrupt_mask = '0;
        stall_prev   = 1'b0;
        ram_if.ready = 1'b1;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();

        $display("[TB] full array, ready high");
        apply_stimulus(5'd0, 32, 16'h1000, 67, -1);

        $display("[TB] wrapping region");
        apply_stimulus(5'd30, 4, 16'hABCD, 11, -1);

        $display("[TB] ready stall on write k=2");
        apply_stimulus(5'd10, 4, 16'h0042, 14, 2);

        $display("[TB] corrupted reads at 5 and 9");
        corrupt_mask = (32'd1 << 5) | (32'd1 << 9);
        apply_stimulus(5'd0, 16, 16'h7FF0, 35, -1);
        corrupt_mask = '0;

        $display("[TB] zero length");
        apply_stimulus(5'd7, 0, 16'h1234, 2, -1);

        $display("[TB] randomized commands");
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [ADDRESS-1:0] rb;
            int                 rn;
            logic [WIDTH-1:0]   rs;
            rb = ADDRESS'($urandom_range(0, DEPTH - 1));
            rn = int'($urandom_range(1, DEPTH));
            rs = WIDTH'($urandom);
            corrupt_mask = ($urandom_range(0, 1) == 1) ?
                ((32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31))) : '0;
            apply_stimulus(rb, rn, rs, -1, -1);
        end
        rand_ready   = 1'b0;
        ram_if.ready = 1'b1;
        corrupt_mask = '0;

        $display("[TB] abort during read k=3");
        push_expected(5'd20, 8, 16'h5555, 4, 1'b1, p);
        tick();
        base  = 5'd20;
        len   = 6'd8;
        seed  = 16'h5555;
        start = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 1;
        while (!(ram_if.rd_en && ram_if.rd_addr == 5'd23) && cycles < 500) begin
            tick();
            cycles++;
        end
        check_output("reached read k=3", ram_if.rd_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_output("rd_en dropped after abort", ram_if.rd_en, 0);
        check_output("cs low after abort", ram_if.cs, 0);
        cycles = 0;
        while (!done && cycles < 20) begin
            tick();
            cycles++;
        end
        check_output("abort done seen", done, 1);
        tick();
        check_output("abort pass held", pass, p);
        check_output("abort reads outstanding", 32'(rd_q.size()), 0);
        if (!done && cycles >= 20) flush_queues();

        $display("[TB] reset mid-write");
        push_expected(5'd0, 16, 16'h0F0F, 0, 1'b0, p);
        res_q.delete();
        tick();
        base  = 5'd0;
        len   = 6'd16;
        seed  = 16'h0F0F;
        start = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 1;
        while (!(ram_if.cs && ram_if.wr_addr == 5'd3) && cycles < 500) begin
            tick();
            cycles++;
        end
        check_output("reached write k=3", ram_if.cs, 1);
        rst = 1'b1;
        tick();
        flush_queues();
        check_zero("mid-write reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_output("idle after reset busy", busy, 0);
        check_output("idle after reset cs", ram_if.cs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
